branch_predictor: RTL and testbench
===================================

Name: branch_predictor

Overview:
- Fetch-side branch predictor: a direct-mapped BTB with one 2-bit saturating counter per entry.
- Fetch uses it each cycle to produce a predicted next PC and a taken flag for the current fetch PC. These travel down the pipeline as btb_predicted_pc / branch_is_taken_prediction.
- It consumes the resolution signals the execute stage produces (increment/decrement counter, unconditional branch, resolved target, mispredict) to train its tables.
- It also keeps a mispredict performance counter.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, 4..256.
- IDX_W, $clog2(ENTRIES), index width; PC bits [IDX_W+1:2].
- TAG_W, 30-IDX_W, tag width; PC bits [31:IDX_W+2].

Ports:
- clk_i  input  1  clock; all state updates on its rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- pc_if_i  input  32  current fetch PC; lookup address.
- btb_predicted_pc_if_o  output  32  predicted next PC.
- branch_is_taken_prediction_if_o  output  1  1 = predicted taken.
- pc_ex_i  input  32  PC of the instruction resolving in execute.
- branch_target_ex_i  input  32  resolved taken target (execute ALU result).
- increment_counter_ex_i  input  1  conditional branch resolved taken.
- decrement_counter_ex_i  input  1  conditional branch resolved not taken.
- unconditional_branch_ex_i  input  1  JAL/JALR resolving in execute.
- branching_ex_i  input  1  execute-stage mispredict/redirect.
- stall_ex_i  input  1  execute held (peripheral stall); blocks all training.
- mispredict_count_o  output  32  saturating count of mispredicts.

Behaviour:
- Per-entry state: valid, jump, tag[TAG_W-1:0], target[31:0], ctr[1:0].
- Reset (rst_ni=0, asynchronous):
  - all valid=0, jump=0, ctr=2'b01 (weakly not taken); tag and target cleared to 0.
  - mispredict_count_o=0.
  - Reset asserted mid-training drops any pending update.
- Lookup (combinational, zero latency):
  - idx=pc_if_i[IDX_W+1:2].
  - hit = valid[idx] && tag[idx]==pc_if_i[31:IDX_W+2].
  - taken = hit && (jump[idx] || ctr[idx][1]).
  - btb_predicted_pc_if_o = taken ? target[idx] : pc_if_i+4, with 32-bit wrap (0xFFFFFFFC -> 0x00000000).
  - During reset both outputs follow from the cleared tables: not taken, pc_if_i+4.
- Training, rising edge, only when stall_ex_i=0:
  - Indexed and tagged by pc_ex_i in the same way as lookup.
  - Exactly one update per resolved instruction. Stalled cycles perform no update, so one update occurs on the first unstalled cycle.
  - unconditional_branch_ex_i=1 takes priority over increment/decrement:
    - set valid=1, jump=1, tag, target=branch_target_ex_i, ctr=2'b11.
    - overwrites any entry at that index.
  - increment_counter_ex_i=1:
    - Hit: ctr=min(ctr+1,3); target=branch_target_ex_i; jump unchanged.
    - Miss: allocate (replace) with valid=1, jump=0, tag, target=branch_target_ex_i, ctr=2'b10.
  - decrement_counter_ex_i=1:
    - Hit with jump=0: ctr=max(ctr-1,0).
    - Miss, or hit with jump=1: no change, no allocation.
  - increment and decrement both 1 (illegal): no table change. Simulation assertion fires.
- Read/write same index in the same cycle: lookup returns pre-update contents. The new state is visible from the next cycle. No bypass.
- mispredict_count_o:
  - +1 on each rising edge with branching_ex_i=1 && stall_ex_i=0.
  - Saturates at 0xFFFFFFFF.
- No other state. No internal FSM beyond per-entry counters (states SNT=00, WNT=01, WT=10, ST=11).

Test Plan:
- Reset, pc_if_i=0x100 -> taken=0, predicted=0x104. pc_if_i=0xFFFFFFFC -> predicted=0x00000000.
- increment at pc_ex_i=0x100, target 0x200, for one cycle -> next cycle pc_if_i=0x100 gives taken=1, predicted=0x200 (ctr=10).
- From that state: decrement x3 -> ctr 01, 00, 00 (saturate) -> taken=0, predicted=0x104. Then increment x1 -> ctr 01, still not taken. Increment again -> taken, 0x200.
- Aliasing (ENTRIES=16): train 0x100 taken, then increment at 0x140 target 0x300 (same idx 0, different tag) -> 0x140 predicts 0x300; 0x100 misses, predicts 0x104. A decrement at a missing PC 0x180 -> no entry for 0x180 is created.
- Stall: entry at 0x100 has ctr=10. Hold increment with stall_ex_i=1 for 3 cycles -> no change, mispredict_count_o unchanged even with branching_ex_i=1. Deassert stall for 1 cycle -> ctr=11 once, count +1 only if branching_ex_i=1.
- Jump plus reset:
  - unconditional at 0x300 target 0x80 -> taken, 0x80.
  - decrement at 0x300 -> still taken.
  - Simultaneous lookup/update at 0x300 shows old value that cycle.
  - Pulse rst_ni low mid-sequence -> next lookup not taken, 0x304; mispredict_count_o=0.

Source files
------------

// File: rtl/branch_predictor.sv
// branch_predictor
//   Fetch-side branch predictor: a direct-mapped BTB where each entry holds a
//   valid bit, a jump (unconditional) bit, a tag, a target and a 2-bit
//   saturating direction counter (SNT=00, WNT=01, WT=10, ST=11).
//   The lookup is combinational and has zero latency. Training happens on the
//   rising edge from execute-stage resolution signals. The block also keeps a
//   saturating mispredict counter.
//
// Ports
//   clk_i                           clock, rising-edge state updates
//   rst_ni                          asynchronous active-low reset
//   pc_if_i                         fetch PC (lookup address)
//   btb_predicted_pc_if_o           predicted next PC
//   branch_is_taken_prediction_if_o 1 = predicted taken
//   pc_ex_i                         PC of instruction resolving in execute
//   branch_target_ex_i              resolved taken target
//   increment_counter_ex_i          conditional branch resolved taken
//   decrement_counter_ex_i          conditional branch resolved not taken
//   unconditional_branch_ex_i       JAL/JALR resolving in execute
//   branching_ex_i                  execute-stage mispredict/redirect
//   stall_ex_i                      execute held; blocks all training
//   mispredict_count_o              saturating mispredict count
//
// Handshake note: this block has no valid/ready interface. Every unstalled
// edge consumes whatever resolution signals execute presents, and a stalled
// edge consumes nothing. Execute therefore holds one resolution steady across
// its stall, and that resolution is applied exactly once.
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES),
    parameter int TAG_W   = 30 - IDX_W
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] pc_if_i,
    output logic [31:0] btb_predicted_pc_if_o,
    output logic        branch_is_taken_prediction_if_o,
    input  logic [31:0] pc_ex_i,
    input  logic [31:0] branch_target_ex_i,
    input  logic        increment_counter_ex_i,
    input  logic        decrement_counter_ex_i,
    input  logic        unconditional_branch_ex_i,
    input  logic        branching_ex_i,
    input  logic        stall_ex_i,
    output logic [31:0] mispredict_count_o
);

    // Per-entry direction counter states.
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    logic             valid_q  [ENTRIES];
    logic             jump_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [31:0]      count_q;

    // ------------------------------------------------------------------
    // Lookup. This path reads the registered tables only, so an update in
    // the same cycle becomes visible on the next cycle.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic             if_taken;

    assign if_idx   = pc_if_i[IDX_W+1:2];
    assign if_tag   = pc_if_i[31:IDX_W+2];
    assign if_hit   = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign if_taken = if_hit && (jump_q[if_idx] || ctr_q[if_idx][1]);

    assign branch_is_taken_prediction_if_o = if_taken;
    assign btb_predicted_pc_if_o           = if_taken ? target_q[if_idx]
                                                      : (pc_if_i + 32'd4);

    // ------------------------------------------------------------------
    // Training
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;

    assign ex_idx = pc_ex_i[IDX_W+1:2];
    assign ex_tag = pc_ex_i[31:IDX_W+2];
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                jump_q[i]   <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WNT;
            end
        end else if (!stall_ex_i) begin
            if (unconditional_branch_ex_i) begin
                // Unconditional branches always own their slot.
                valid_q[ex_idx]  <= 1'b1;
                jump_q[ex_idx]   <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= branch_target_ex_i;
                ctr_q[ex_idx]    <= CTR_ST;
            end else if (increment_counter_ex_i && !decrement_counter_ex_i) begin
                if (ex_hit) begin
                    if (ctr_q[ex_idx] != CTR_ST) begin
                        ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
                    end
                    target_q[ex_idx] <= branch_target_ex_i;
                end else begin
                    // A taken conditional branch allocates and starts out weakly taken.
                    valid_q[ex_idx]  <= 1'b1;
                    jump_q[ex_idx]   <= 1'b0;
                    tag_q[ex_idx]    <= ex_tag;
                    target_q[ex_idx] <= branch_target_ex_i;
                    ctr_q[ex_idx]    <= CTR_WT;
                end
            end else if (decrement_counter_ex_i && !increment_counter_ex_i) begin
                // Not-taken only trains an existing conditional entry. It never
                // allocates and never weakens a jump entry.
                if (ex_hit && !jump_q[ex_idx] && (ctr_q[ex_idx] != CTR_SNT)) begin
                    ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Mispredict counter, saturating
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (branching_ex_i && !stall_ex_i && (count_q != 32'hFFFF_FFFF)) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign mispredict_count_o = count_q;

    // The PCs are word aligned, so the low two bits carry no information.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{pc_if_i[1:0], pc_ex_i[1:0]};

    // Raising increment and decrement together is illegal. The tables are left unchanged.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(increment_counter_ex_i && decrement_counter_ex_i));

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor
//   Directed test of branch_predictor (ENTRIES=16) using hand-computed
//   expectations. The stimulus covers reset, counter walks, aliasing,
//   stalls, jump entries, same-cycle read/write behaviour and a reset pulse.
module tb_branch_predictor;

    logic        clk_i;
    logic        rst_ni;
    logic [31:0] pc_if_i;
    logic [31:0] btb_predicted_pc_if_o;
    logic        branch_is_taken_prediction_if_o;
    logic [31:0] pc_ex_i;
    logic [31:0] branch_target_ex_i;
    logic        increment_counter_ex_i;
    logic        decrement_counter_ex_i;
    logic        unconditional_branch_ex_i;
    logic        branching_ex_i;
    logic        stall_ex_i;
    logic [31:0] mispredict_count_o;

    int total_cnt = 0;
    int bad_cnt   = 0;
    logic [31:0] exp_q[$];

    branch_predictor dut (
        .clk_i                           (clk_i),
        .rst_ni                          (rst_ni),
        .pc_if_i                         (pc_if_i),
        .btb_predicted_pc_if_o           (btb_predicted_pc_if_o),
        .branch_is_taken_prediction_if_o (branch_is_taken_prediction_if_o),
        .pc_ex_i                         (pc_ex_i),
        .branch_target_ex_i              (branch_target_ex_i),
        .increment_counter_ex_i          (increment_counter_ex_i),
        .decrement_counter_ex_i          (decrement_counter_ex_i),
        .unconditional_branch_ex_i       (unconditional_branch_ex_i),
        .branching_ex_i                  (branching_ex_i),
        .stall_ex_i                      (stall_ex_i),
        .mispredict_count_o              (mispredict_count_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // ---------------- scoreboard ----------------
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Push the expected lookup result, then check it against the DUT once the combinational path has settled.
    task automatic expect_lookup(input string tag, input logic [31:0] pc,
                                 input logic taken, input logic [31:0] npc);
        exp_q.push_back({31'b0, taken});
        exp_q.push_back(npc);
        pc_if_i = pc;
        #1;
        check_val({tag, "_taken"}, {31'b0, branch_is_taken_prediction_if_o}, exp_q.pop_front());
        check_val({tag, "_pc"}, btb_predicted_pc_if_o, exp_q.pop_front());
    endtask

    task automatic expect_count(input string tag, input logic [31:0] cnt);
        exp_q.push_back(cnt);
        check_val(tag, mispredict_count_o, exp_q.pop_front());
    endtask

    // ---------------- drivers ----------------
    task automatic clear_ex();
        pc_ex_i                   = '0;
        branch_target_ex_i        = '0;
        increment_counter_ex_i    = 1'b0;
        decrement_counter_ex_i    = 1'b0;
        unconditional_branch_ex_i = 1'b0;
        branching_ex_i            = 1'b0;
        stall_ex_i                = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_ex(input logic [31:0] pc, input logic [31:0] tgt,
                          input logic inc, input logic dec, input logic unc,
                          input logic br, input logic stall);
        pc_ex_i                   = pc;
        branch_target_ex_i        = tgt;
        increment_counter_ex_i    = inc;
        decrement_counter_ex_i    = dec;
        unconditional_branch_ex_i = unc;
        branching_ex_i            = br;
        stall_ex_i                = stall;
    endtask

    // Drive one resolution for a single unstalled edge.
    task automatic train(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic inc, input logic dec, input logic unc, input logic br);
        set_ex(pc, tgt, inc, dec, unc, br, 1'b0);
        tick();
        clear_ex();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        clear_ex();
        pc_if_i = '0;
        rst_ni  = 1'b0;
        #2;
        // Reset state
        expect_lookup("rst_100", 32'h100, 1'b0, 32'h104);
        expect_lookup("rst_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);
        expect_count("rst_cnt", 32'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        expect_lookup("post_rst", 32'h100, 1'b0, 32'h104);

        // Allocate 0x100 as weakly taken
        train(32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_lookup("alloc", 32'h100, 1'b1, 32'h200);

        // Walk down: 10 -> 01 -> 00 -> 00
        train(32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_lookup("dec1", 32'h100, 1'b0, 32'h104);
        train(32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        train(32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_lookup("dec3", 32'h100, 1'b0, 32'h104);
        // 00 -> 01 still not taken, then 01 -> 10 taken
        train(32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_lookup("inc1", 32'h100, 1'b0, 32'h104);
        train(32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_lookup("inc2", 32'h100, 1'b1, 32'h200);
        // A hit on increment refreshes the target
        train(32'h100, 32'h220, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_lookup("retarget", 32'h100, 1'b1, 32'h220);

        // Aliasing: 0x140 shares index 0 with a different tag
        train(32'h140, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_lookup("alias_new", 32'h140, 1'b1, 32'h300);
        expect_lookup("alias_old", 32'h100, 1'b0, 32'h104);
        // A decrement that misses must not allocate or disturb the entry
        train(32'h180, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_lookup("dec_miss", 32'h180, 1'b0, 32'h184);
        expect_lookup("dec_miss_keep", 32'h140, 1'b1, 32'h300);
        expect_count("cnt_zero", 32'd0);

        // Stall: reallocate 0x100 at ctr=10
        train(32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0);
        expect_lookup("stall_base", 32'h100, 1'b1, 32'h200);
        // A stalled decrement with branching must do nothing
        set_ex(32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        repeat (3) tick();
        expect_lookup("stall_dec", 32'h100, 1'b1, 32'h200);
        expect_count("stall_cnt_a", 32'd0);
        // Stalled increment for 3 cycles, then one unstalled cycle
        set_ex(32'h100, 32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) tick();
        expect_count("stall_cnt_b", 32'd0);
        stall_ex_i = 1'b0;
        tick();
        clear_ex();
        expect_count("unstall_cnt", 32'd1);
        // ctr must be 11: one decrement keeps taken, the next does not
        train(32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_lookup("st_dec1", 32'h100, 1'b1, 32'h200);
        train(32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_lookup("st_dec2", 32'h100, 1'b0, 32'h104);
        // A branching cycle with no training still counts
        train(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_count("br_only", 32'd2);

        // Jump entries
        train(32'h300, 32'h80, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_lookup("jal", 32'h300, 1'b1, 32'h80);
        train(32'h300, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        expect_lookup("jal_dec", 32'h300, 1'b1, 32'h80);
        // Same-cycle lookup and update at index 0: the old contents show until the edge
        set_ex(32'h140, 32'h400, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        expect_lookup("same_old_300", 32'h300, 1'b1, 32'h80);
        expect_lookup("same_old_140", 32'h140, 1'b0, 32'h144);
        tick();
        clear_ex();
        expect_lookup("same_new_140", 32'h140, 1'b1, 32'h400);
        expect_lookup("same_new_300", 32'h300, 1'b0, 32'h304);
        expect_count("cnt_pre_rst", 32'd3);
        // Unconditional takes priority over a simultaneous increment
        train(32'h300, 32'h80, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_lookup("unc_prio", 32'h300, 1'b1, 32'h80);

        // Reset pulse in mid-cycle with an update pending
        set_ex(32'h100, 32'h500, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        rst_ni = 1'b0;
        #1;
        expect_lookup("rst_pulse_300", 32'h300, 1'b0, 32'h304);
        expect_count("rst_pulse_cnt", 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        clear_ex();
        tick();
        expect_lookup("after_pulse_300", 32'h300, 1'b0, 32'h304);
        expect_lookup("after_pulse_100", 32'h100, 1'b0, 32'h104);
        expect_count("after_pulse_cnt", 32'd0);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
